// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: walks every operand pair through a comparator and checks its result
module cmp_sweep_driver #(
  parameter int WIDTH         = 3,
  parameter int CMP_OP        = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               dut_result,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam int IW = 2 * WIDTH;
  localparam logic [3:0]    SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [IW-1:0] IDX_ONE = 1;
  localparam logic [IW:0]   ERR_ONE = 1;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [IW:0]       err_q, err_d;
  logic [WIDTH-1:0]  fa_q, fa_d, fb_q, fb_d;
  logic              ref_bit, mism;
  assign a_out     = idx_q[IW-1:WIDTH];
  assign b_out     = idx_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  // Reference function; unknown CMP_OP values fall back to equality
  assign ref_bit = (CMP_OP == 1) ? (a_out > b_out) : (CMP_OP == 2) ? (a_out < b_out) : (a_out == b_out);
  assign mism    = dut_result != ref_bit;
  // Next-state and result bookkeeping; abort takes priority over sampling
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == APPLY) begin
          state_d = (cnt_q == SETTLE) ? SAMPLE : APPLY;
          cnt_d   = (cnt_q == SETTLE) ? cnt_q : cnt_q + 4'd1;
        end else begin
          if (mism) begin
            err_d = err_q + ERR_ONE;
            fa_d  = (err_q == '0) ? a_out : fa_q;
            fb_d  = (err_q == '0) ? b_out : fb_q;
          end
          if (idx_q == '1) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            state_d = APPLY;
            idx_d   = idx_q + IDX_ONE;
            cnt_d   = 4'd1;
          end
        end
      end
    endcase
  end
  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end
endmodule
